// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: command-driven SPI frame generator.
// Each accepted command becomes one frame. The frame is a select cycle, then
// 10 bits of {cmd_type, cmd_data} sent MSB first. A read-data command adds a
// turnaround and an 8-bit MISO capture. Every frame ends with a
// slave-deselect gap. A read-data command is refused, with an err pulse,
// unless a read-address frame has completed since the last read-data frame.
// TURN_CYCLES and GAP_CYCLES must both be at least 1.
module spi_master_ctrl #(
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       err,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int FRAME_BITS = 10;
    localparam int READ_BITS  = 8;

    // The shared down-counter must hold the longest phase length.
    localparam int MAX_A   = (TURN_CYCLES > FRAME_BITS) ? TURN_CYCLES : FRAME_BITS;
    localparam int MAX_CNT = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [1:0] T_RD_ADDR = 2'b10;
    localparam logic [1:0] T_RD_DATA = 2'b11;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       frame_sr;    // outgoing frame; bit 9 is on mosi
    logic [1:0]       frame_type;  // type of the frame in flight
    logic [6:0]       rd_sr;       // MISO bits collected so far
    logic             addr_ok;     // a read address has been sent
    logic             ready_en;    // holds off cmd_ready until the first edge after reset

    // Decode the SPI pins and handshake outputs from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cmd_ready = 1'b0;
        busy      = 1'b1;
        ss_n      = 1'b0;
        mosi      = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready = ready_en;
                busy      = 1'b0;
                ss_n      = 1'b1;
            end
            S_SEL, S_SHIFT: mosi = frame_sr[9];
            S_TURN, S_READ: mosi = 1'b1;
            S_GAP:          ss_n = 1'b1;
            default: begin
                busy = 1'b0;
                ss_n = 1'b1;
            end
        endcase
    end

    // Frame sequencer: state register, phase counter, shift registers and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= CNT_ZERO;
            frame_sr   <= '0;
            frame_type <= 2'b00;
            rd_sr      <= '0;
            rsp_data   <= 8'h00;
            rsp_valid  <= 1'b0;
            err        <= 1'b0;
            addr_ok    <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            ready_en  <= 1'b1;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        frame_sr   <= {cmd_type, cmd_data};
                        frame_type <= cmd_type;
                        if (cmd_type == T_RD_DATA && !addr_ok) begin
                            // Refused read: no frame, just the deselect gap.
                            err   <= 1'b1;
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state <= S_SEL;
                            cnt   <= CNT_ZERO;
                        end
                    end
                end
                S_SEL: begin
                    // frame_sr is not shifted here, so bit 9 is sent again as the first SHIFT bit.
                    state <= S_SHIFT;
                    cnt   <= SHIFT_LOAD;
                end
                S_SHIFT: begin
                    frame_sr <= {frame_sr[8:0], 1'b0};
                    if (cnt == CNT_ZERO) begin
                        if (frame_type == T_RD_DATA) begin
                            state <= S_TURN;
                            cnt   <= TURN_LOAD;
                        end else begin
                            if (frame_type == T_RD_ADDR) begin
                                addr_ok <= 1'b1;
                            end
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_TURN: begin
                    if (cnt == CNT_ZERO) begin
                        state <= S_READ;
                        cnt   <= READ_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_READ: begin
                    rd_sr <= {rd_sr[5:0], miso};
                    if (cnt == CNT_ZERO) begin
                        // rsp_data changes only when a full byte has been read.
                        rsp_data  <= {rd_sr, miso};
                        rsp_valid <= 1'b1;
                        addr_ok   <= 1'b0;
                        state     <= S_GAP;
                        cnt       <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_ZERO) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl.
// Stimulus pushes the frame, response and error it expects. Monitors pop and
// compare those whenever the DUT shows a frame, an rsp_valid pulse or an err
// pulse.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int TURN = 2;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       err;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    spi_master_ctrl #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .err       (err),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] bits;
    } frame_t;

    frame_t      exp_frames[$];
    logic [7:0]  exp_rsp[$];
    int          exp_err[$];

    int          total = 0;
    int          bad   = 0;
    bit          model_addr_ok = 1'b0;
    logic [7:0]  slave_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push what a command should produce: a full frame, a read byte, or an err pulse.
    task automatic model_push(input logic [1:0] t, input logic [7:0] d);
        frame_t f;
        if (t == 2'b11 && !model_addr_ok) begin
            exp_err.push_back(1);
        end else begin
            f.bits = {21'b0, t[1], t, d};
            f.len  = 11;
            if (t == 2'b11) begin
                f.bits = (f.bits << 10) | 32'h3FF;
                f.len  = 11 + TURN + 8;
                exp_rsp.push_back(slave_byte);
                model_addr_ok = 1'b0;
            end else if (t == 2'b10) begin
                model_addr_ok = 1'b1;
            end
            exp_frames.push_back(f);
        end
    endtask

    // Present one command for a single accepting edge. Caller ensures cmd_ready is high.
    task automatic issue(input logic [1:0] t, input logic [7:0] d, input bit expect_full);
        if (expect_full) model_push(t, d);
        cmd_type  = t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    // Slave model: shifts slave_byte out MSB first during the READ cycles of a frame.
    int slave_cnt = 0;
    int slave_r;
    always @(negedge clk) begin
        if (!ss_n) begin
            slave_r = slave_cnt - (11 + TURN);
            miso = (slave_r >= 0 && slave_r < 8) ? slave_byte[7 - slave_r] : 1'b0;
            slave_cnt++;
        end else begin
            slave_cnt = 0;
            miso = 1'b0;
        end
    end

    // Monitor: capture mosi while ss_n is low and compare on the rising edge of ss_n.
    int          cap_len  = 0;
    logic [31:0] cap_bits = '0;
    frame_t      mon_f;
    logic [7:0]  mon_b;
    always @(negedge clk) begin
        if (!ss_n) begin
            cap_bits = {cap_bits[30:0], mosi};
            cap_len++;
        end else if (cap_len > 0) begin
            if (exp_frames.size() > 0) begin
                mon_f = exp_frames.pop_front();
                check("frame_len", cap_len, mon_f.len);
                check("frame_bits", cap_bits, mon_f.bits);
            end else begin
                check("frame_unexpected", cap_len, 0);
            end
            cap_len  = 0;
            cap_bits = '0;
        end
        if (rsp_valid) begin
            if (exp_rsp.size() > 0) begin
                mon_b = exp_rsp.pop_front();
                check("rsp_data", rsp_data, mon_b);
            end else begin
                check("rsp_valid_unexpected", rsp_valid, 0);
            end
        end
        if (err) begin
            if (exp_err.size() > 0) begin
                void'(exp_err.pop_front());
            end else begin
                check("err_unexpected", err, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_mosi", mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err", err, 0);
        check("rst_rsp_data", rsp_data, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", cmd_ready, 1);

        // Read-data with no prior read-address: refused.
        issue(2'b11, 8'h00, 1'b1);
        check("refused_ss_n", ss_n, 1);
        check("refused_busy", busy, 1);
        wait_ready("refused_ready", GAP);

        // Write address 0xAB and write data 0xAA.
        issue(2'b00, 8'hAB, 1'b1);
        wait_ready("wr_addr_ready", 13);
        issue(2'b01, 8'hAA, 1'b1);
        wait_ready("wr_data_ready", 13);

        // Read address 0xAD, then read data; slave returns 0x5C.
        slave_byte = 8'h5C;
        issue(2'b10, 8'hAD, 1'b1);
        wait_ready("rd_addr_ready", 13);
        issue(2'b11, 8'h00, 1'b1);
        wait_ready("rd_data_ready", 1 + 10 + TURN + 8 + GAP);
        check("rsp_data_after_read", rsp_data, 8'h5C);

        // The read cleared addr_ok, so a second read-data is refused and rsp_data holds.
        issue(2'b11, 8'h00, 1'b1);
        wait_ready("second_read_refused", GAP);
        check("rsp_data_hold", rsp_data, 8'h5C);

        // Reset in the middle of SHIFT: the partial frame is SEL plus five bits.
        begin
            frame_t f;
            f.bits = {21'b0, 3'b000, 8'h96} >> 5;
            f.len  = 6;
            exp_frames.push_back(f);
        end
        issue(2'b00, 8'h96, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        model_addr_ok = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 1);
        check("abort_busy", busy, 0);
        check("abort_mosi", mosi, 1);
        check("abort_rsp_data", rsp_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_abort", cmd_ready, 1);
        issue(2'b00, 8'h5A, 1'b1);
        wait_ready("post_abort_ready", 13);

        // cmd_valid held through a frame: one accept per IDLE visit.
        model_push(2'b00, 8'h3C);
        model_push(2'b00, 8'hC3);
        cmd_type  = 2'b00;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_data = 8'hC3;
        repeat (13) @(posedge clk);
        #1;
        check("held_idle_reentry", cmd_ready, 1);
        @(posedge clk);
        #1;
        check("held_second_start_ss_n", ss_n, 0);
        check("held_second_start_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_ready("held_second_ready", 13);

        repeat (5) @(posedge clk);
        #1;
        check("frames_left", exp_frames.size(), 0);
        check("rsp_left", exp_rsp.size(), 0);
        check("err_left", exp_err.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
